// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Shared definitions for the execute-stage ALU/MDU: funct codes,
//            multiply/divide sequencer states and width-derived helpers.
//  Ports   : none (package)
//  Revision: 1.0 - initial parametrised release
// ============================================================================
package alu_pkg;

  // Funct codes carried on the Signal bus
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // Legal datapath widths
  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Width of an iteration counter that must count 0..w-1
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mdu_param_if.sv
`default_nettype none
// ============================================================================
//  Module  : alu_mdu_param_if
//  Brief   : Request/response bundle between the register-read stage, the
//            ALU/MDU and writeback.
//  Ports   : in_valid/in_ready request handshake, Signal funct code,
//            dataA/dataB operands, out_valid result pulse, Output result,
//            busy multiply/divide in progress.
//  Revision: 1.0 - initial parametrised release
// ============================================================================
interface alu_mdu_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             out_valid;
  logic [WIDTH-1:0] Output;
  logic             busy;

  modport master (
    output in_valid, Signal, dataA, dataB,
    input  in_ready, out_valid, Output, busy
  );

  modport slave (
    input  in_valid, Signal, dataA, dataB,
    output in_ready, out_valid, Output, busy
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module  : mdu_iter
//  Brief   : Iterative unsigned multiply (radix-2 shift-add) and restoring
//            divide, one iteration per clock, WIDTH iterations per operation.
//  Ports   : clk, reset (async, active-high)
//            start_i  load operands and clear counter
//            div_i    1 = divide, 0 = multiply (sampled with start_i)
//            run_i    iterate this cycle (owner's FSM is in MUL/DIV)
//            a_i/b_i  multiplicand|dividend / multiplier|divisor
//            done_o   final iteration happens on the coming edge
//            hi_o/lo_o result of the current iteration (valid with done_o)
//  Revision: 1.0 - initial parametrised release
// ============================================================================
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start_i,
  input  wire logic             div_i,
  input  wire logic             run_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic      [WIDTH-1:0] hi_o,
  output logic      [WIDTH-1:0] lo_o
);

  localparam int CW = cnt_width(WIDTH);

  // acc: partial product high half / partial remainder
  // mq : multiplier being consumed / dividend shifting out, quotient in
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q,  mq_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, mq_q[WIDTH-1]};
    // One extra bit so the borrow is visible even when div_shift[WIDTH] is set
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    if (div_q) begin
      if (div_diff[WIDTH+1]) begin
        acc_d = div_shift[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end else begin
        // Divisor zero always lands here: quotient all ones, remainder = dividend
        acc_d = div_diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
  end

  assign done_o = run_i && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = acc_d;
  assign lo_o   = mq_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      mq_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= '0;
      mq_q  <= a_i;
      b_q   <= b_i;
      cnt_q <= '0;
      div_q <= div_i;
    end else if (run_i) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      // WIDTH is a power of two, so the counter wraps to 0 after the last step
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mdu_param.sv
`default_nettype none
// ============================================================================
//  Module  : alu_mdu_param
//  Brief   : Execute-stage ALU, shifter, iterative MULTU/DIVU, HI/LO pair
//            and registered result under one valid/ready handshake.
//  Ports   : clk    rising-edge clock
//            reset  asynchronous active-high reset
//            bus    alu_mdu_param_if slave (in_valid/in_ready, Signal,
//                   dataA, dataB, out_valid, Output, busy)
//  Revision: 1.0 - initial parametrised release
// ============================================================================
module alu_mdu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_mdu_param_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             out_valid_q;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic [WIDTH-1:0] w_alu;
  logic             w_mdu_done;
  logic [WIDTH-1:0] w_mdu_hi;
  logic [WIDTH-1:0] w_mdu_lo;

  assign w_accept = bus.in_valid && (state_q == ST_IDLE);
  assign w_is_mul = (bus.Signal == F_MULTU);
  assign w_is_div = (bus.Signal == F_DIVU);

  // Single-cycle result; MFHI/MFLO read only committed HI/LO
  always_comb begin
    w_alu = '0;
    case (bus.Signal)
      F_AND:  w_alu = bus.dataA & bus.dataB;
      F_OR:   w_alu = bus.dataA | bus.dataB;
      F_ADD:  w_alu = bus.dataA + bus.dataB;
      F_SUB:  w_alu = bus.dataA - bus.dataB;
      F_SLT:  w_alu = ($signed(bus.dataA) < $signed(bus.dataB)) ? WIDTH'(1) : '0;
      F_SLL:  w_alu = bus.dataA << bus.dataB[SHW-1:0];
      F_SRL:  w_alu = bus.dataA >> bus.dataB[SHW-1:0];
      F_MFHI: w_alu = hi_q;
      F_MFLO: w_alu = lo_q;
      default: w_alu = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_accept && (w_is_mul || w_is_div)),
    .div_i   (w_is_div),
    .run_i   (state_q != ST_IDLE),
    .a_i     (bus.dataA),
    .b_i     (bus.dataB),
    .done_o  (w_mdu_done),
    .hi_o    (w_mdu_hi),
    .lo_o    (w_mdu_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              state_q <= ST_MUL;
            end else if (w_is_div) begin
              state_q <= ST_DIV;
            end else begin
              out_q       <= w_alu;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // HI/LO commit atomically on the last iteration edge
          if (w_mdu_done) begin
            hi_q        <= w_mdu_hi;
            lo_q        <= w_mdu_lo;
            out_q       <= w_mdu_lo;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Output    = out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_param.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_mdu_param
//  Brief   : Self-checking bench for alu_mdu_param at WIDTH=32 and WIDTH=16
//            against an arithmetic reference model.
//  Ports   : none
//  Revision: 1.0 - initial release
// ============================================================================
module tb_alu_mdu_param;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   ncomp;
  int   nfail;

  // Reference HI/LO per instance: index 0 = WIDTH 32, 1 = WIDTH 16
  logic [63:0] mhi [2];
  logic [63:0] mlo [2];

  alu_mdu_param_if #(.WIDTH(32)) if32 ();
  alu_mdu_param_if #(.WIDTH(16)) if16 ();

  alu_mdu_param #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  alu_mdu_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_ov(input bit w16);
    return w16 ? if16.out_valid : if32.out_valid;
  endfunction
  function automatic logic sel_rdy(input bit w16);
    return w16 ? if16.in_ready : if32.in_ready;
  endfunction
  function automatic logic sel_busy(input bit w16);
    return w16 ? if16.busy : if32.busy;
  endfunction
  function automatic logic [63:0] sel_out(input bit w16);
    return w16 ? {48'd0, if16.Output} : {32'd0, if32.Output};
  endfunction

  // Reference model: plain integer arithmetic on w-bit unsigned values
  task automatic model(input int w, input logic [5:0] f, input logic [63:0] a,
                       input logic [63:0] b, input int idx, output logic [63:0] res);
    logic [63:0]  mask;
    logic [127:0] p;
    longint       sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    case (f)
      F_AND:  res = a & b;
      F_OR:   res = a | b;
      F_ADD:  res = (a + b) & mask;
      F_SUB:  res = (a - b) & mask;
      F_SLT:  res = (sa < sb) ? 64'd1 : 64'd0;
      F_SLL:  res = (a << (b % 64'(w))) & mask;
      F_SRL:  res = a >> (b % 64'(w));
      F_MFHI: res = mhi[idx];
      F_MFLO: res = mlo[idx];
      F_MULTU: begin
        p = 128'(a) * 128'(b);
        mhi[idx] = 64'(p >> w) & mask;
        mlo[idx] = 64'(p) & mask;
        res = mlo[idx];
      end
      F_DIVU: begin
        if (b == 64'd0) begin
          mlo[idx] = mask;
          mhi[idx] = a;
        end else begin
          mlo[idx] = a / b;
          mhi[idx] = a % b;
        end
        res = mlo[idx];
      end
      default: res = 64'd0;
    endcase
  endtask

  task automatic drive(input bit w16, input logic v, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if32.Signal = f;  if16.Signal = f;
    if32.dataA  = a;  if16.dataA  = a[15:0];
    if32.dataB  = b;  if16.dataB  = b[15:0];
    if32.in_valid = v && !w16;
    if16.in_valid = v && w16;
  endtask

  // Issue one operation (called #1 after a rising edge) and check latency,
  // stall behaviour and result.
  task automatic do_op(input bit w16, input logic [5:0] f, input logic [31:0] a_in,
                       input logic [31:0] b_in, input string tag);
    logic [63:0] exp;
    logic [31:0] a, b;
    int w, n, exp_lat;
    bit mdu, stall_bad;
    w   = w16 ? 16 : 32;
    a   = w16 ? (a_in & 32'hFFFF) : a_in;
    b   = w16 ? (b_in & 32'hFFFF) : b_in;
    mdu = (f == F_MULTU) || (f == F_DIVU);
    exp_lat = mdu ? w : 0;
    model(w, f, 64'(a), 64'(b), w16 ? 1 : 0, exp);
    drive(w16, 1'b1, f, a, b);
    chk({tag, "_rdy"}, 64'(sel_rdy(w16)), 64'd1);
    @(posedge clk); #1;
    drive(w16, 1'b0, f, a, b);
    n = 0;
    stall_bad = 1'b0;
    while (!sel_ov(w16) && n < w + 4) begin
      if (sel_rdy(w16) || !sel_busy(w16)) stall_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    if (mdu) chk({tag, "_stall"}, 64'(stall_bad), 64'd0);
    chk({tag, "_out"}, sel_out(w16), exp);
  endtask

  initial begin
    logic [63:0] q;
    int n;
    bit seen;
    logic [5:0] fl [12];
    ncomp = 0;
    nfail = 0;
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    fl = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL,
           F_MULTU, F_DIVU, F_MFHI, F_MFLO, 6'b111111};
    drive(1'b0, 1'b0, F_AND, 32'd0, 32'd0);
    reset = 1'b1;
    #2;
    chk("rst_out",   {32'd0, if32.Output},   64'd0);
    chk("rst_ov",    64'(if32.out_valid),    64'd0);
    chk("rst_busy",  64'(if32.busy),         64'd0);
    chk("rst_rdy",   64'(if32.in_ready),     64'd1);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Directed single-cycle cases
    do_op(0, F_ADD, 32'd5, 32'd7, "add");
    do_op(0, F_SUB, 32'd0, 32'd1, "sub");
    do_op(0, F_SLT, 32'hFFFFFFFF, 32'd1, "slt");
    do_op(0, F_SLL, 32'd1, 32'h23, "sll");
    do_op(0, F_SRL, 32'h80000000, 32'd31, "srl");
    // Multiply/divide and back-to-back HI/LO reads
    do_op(0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    do_op(0, F_MFHI, 32'd0, 32'd0, "mfhi_mul");
    do_op(0, F_MFLO, 32'd0, 32'd0, "mflo_mul");
    do_op(0, F_DIVU, 32'd100, 32'd7, "divu");
    do_op(0, F_MFHI, 32'd0, 32'd0, "mfhi_div");
    do_op(0, F_DIVU, 32'h1234, 32'd0, "divz");
    do_op(0, F_MFHI, 32'd0, 32'd0, "mfhi_divz");
    do_op(0, 6'b111111, 32'h55, 32'h66, "unknown");
    do_op(0, F_MFLO, 32'd0, 32'd0, "mflo_keep");

    // MFLO held valid across a DIVU: must wait and return the new quotient
    model(32, F_DIVU, 64'd1000, 64'd33, 0, q);
    drive(0, 1'b1, F_DIVU, 32'd1000, 32'd33);
    @(posedge clk); #1;
    drive(0, 1'b1, F_MFLO, 32'd0, 32'd0);
    n = 0;
    while (!if32.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_lat", 64'(n), 64'd32);
    chk("hold_div", {32'd0, if32.Output}, q);
    chk("hold_rdy", 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, F_MFLO, 32'd0, 32'd0);
    chk("hold_ov", 64'(if32.out_valid), 64'd1);
    chk("hold_mflo", {32'd0, if32.Output}, mlo[0]);

    // Asynchronous reset in the middle of a multiply
    drive(0, 1'b1, F_MULTU, 32'hDEADBEEF, 32'h12345);
    @(posedge clk); #1;
    drive(0, 1'b0, F_MULTU, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(if32.busy), 64'd0);
    chk("arst_rdy",  64'(if32.in_ready), 64'd1);
    chk("arst_ov",   64'(if32.out_valid), 64'd0);
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.out_valid) seen = 1'b1;
    end
    chk("arst_noov", 64'(seen), 64'd0);
    do_op(0, F_MFHI, 32'd0, 32'd0, "arst_hi");
    do_op(0, F_MFLO, 32'd0, 32'd0, "arst_lo");

    // WIDTH=16 instance
    do_op(1, F_MULTU, 32'hFFFF, 32'h0002, "m16");
    do_op(1, F_MFHI, 32'd0, 32'd0, "m16_hi");
    do_op(1, F_MFLO, 32'd0, 32'd0, "m16_lo");
    do_op(1, F_DIVU, 32'hFFFF, 32'h0000, "d16z");
    do_op(1, F_MFHI, 32'd0, 32'd0, "d16z_hi");

    // Randomized traffic on both widths
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      logic [5:0]  rf;
      bit          r16;
      r16 = (i % 3) == 2;
      rf  = fl[$urandom_range(0, 11)];
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      do_op(r16, rf, ra, rb, r16 ? "rnd16" : "rnd32");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mdu_param.md
Name: alu_mdu_param

Overview:
- Parametrised successor of the execute-stage ALU top. Combines the single-cycle ALU, shifter, a sequential multiply/divide unit, the HI/LO register pair and the result mux under one valid/ready handshake.
- Adds over the previous generation:
  - configurable datapath width
  - unsigned divide (DIVU) alongside MULTU
  - SRL
  - explicit busy stalling, so MFHI/MFLO never read a partial HI/LO
- Sits between the register-read stage and writeback.

Parameters:
- WIDTH, 32, datapath width. Power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- Signal  in  6  funct code (see Behaviour).
- dataA  in  WIDTH  operand A (shift source, dividend, multiplicand).
- dataB  in  WIDTH  operand B (shift amount in [SHW-1:0], divisor, multiplier).
- out_valid  out  1  one-cycle pulse: Output/HI/LO update has completed.
- Output  out  WIDTH  registered result.
- busy  out  1  multiply/divide iteration in progress.

Behaviour:
- Funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010
  - SLL 000000, SRL 000010
  - MULTU 011001, DIVU 011011
  - MFHI 010000, MFLO 010010
- Reset values: Output=0, HI=0, LO=0, out_valid=0, busy=0, in_ready=1, state=IDLE, counter=0. Reset asserted mid-operation aborts it; HI/LO return to 0 and no out_valid is produced.
- Accept: an operation is accepted on an edge where in_valid && in_ready. in_ready = (state==IDLE).
- Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, SRL, MFHI, MFLO): Output registered on the accept edge; out_valid high for the following cycle. Latency 1; one accept per cycle sustained.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is a signed compare; Output = {0..0,1} or 0.
  - SLL/SRL shift dataA by dataB[SHW-1:0]; SRL is logical.
- Unknown funct: Output=0, out_valid still pulses, HI/LO unchanged.
- State machine: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted MULTU.
  - IDLE -> DIV on accepted DIVU.
  - MUL/DIV -> IDLE when counter reaches WIDTH-1.
- MULTU: radix-2 shift-add, one iteration per cycle, WIDTH iterations on edges T1..T(WIDTH).
  - Full 2*WIDTH-bit product: HI = upper half, LO = lower half, loaded at edge T(WIDTH).
  - Output = new LO at the same edge; out_valid high in the following cycle.
- DIVU: restoring division, WIDTH iterations, same timing as MULTU. LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dataA. Still WIDTH cycles.
- busy = (state!=IDLE). in_ready is low from the accept edge through edge T(WIDTH); it is high again during the out_valid cycle.
- HI/LO are visible to MFHI/MFLO only after completion; no partial results are ever visible. MFHI accepted in the out_valid cycle returns the new HI.
- Operands are latched at accept. Input changes while busy have no effect.
- No output backpressure; out_valid is a pulse. The consumer must sample it.

Decomposition:
- Shared package alu_pkg:
  - funct localparams (AND..MFLO)
  - state enum (IDLE/MUL/DIV)
  - WIDTH-derived helper constants
- One natural sub-module: mdu_iter. It holds the iterative multiply/divide datapath (accumulator, operand shift registers, counter, done strobe) and presents start/op/done to the top.
- ALU/shifter/mux logic stays combinational inside the top ahead of the Output register.

Test Plan:
1. WIDTH=32: ADD 5,7 -> Output=0x0000000C, out_valid one cycle after accept. SUB 0,1 -> 0xFFFFFFFF. SLT 0xFFFFFFFF,1 -> 1.
2. SLL 0x00000001 by dataB=0x00000023 (shamt 3) -> 0x00000008. SRL 0x80000000 by 31 -> 0x00000001.
3. MULTU 0xFFFFFFFF*0xFFFFFFFF:
   - in_ready=0 for 32 cycles; out_valid at cycle 33 after accept.
   - HI=0xFFFFFFFE, LO=0x00000001.
   - Back-to-back MFHI in the out_valid cycle -> 0xFFFFFFFE.
4. DIVU 100/7 -> LO=14, HI=2. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, same 32-cycle latency.
5. in_valid held high with MFLO during a DIVU -> not accepted until in_ready rises; it returns the new LO, never a stale or partial value.
6. Reset asserted at cycle 10 of MULTU:
   - busy=0, in_ready=1, HI=LO=0 immediately (asynchronous).
   - No out_valid afterwards.
   - Rerun with WIDTH=16: MULTU 0xFFFF*0x0002 -> HI=0x0001, LO=0xFFFE after 16 cycles.
